// File: rtl/cfg_ramp_seq.sv
// rtl/cfg_ramp_seq.sv - config bus forwarder that ramps RAMP_ADDR writes, with fault lockout
// Optional soft ramp-down: define CFG_RAMP_SOFT_DOWN_EN
module cfg_ramp_seq #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int RAMP_ADDR = 4,
    parameter int RAMP_STEP = 4,
    parameter int RAMP_DIV  = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_en,
    input  logic              fault,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_en,
    output logic [DATA_W-1:0] cur_val,
    output logic              busy,
    output logic              fault_lock
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [ADDR_W-1:0] RA      = ADDR_W'(RAMP_ADDR);
    localparam logic [DATA_W:0]   STEP_X  = (DATA_W+1)'(RAMP_STEP);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(RAMP_DIV - 1);

`ifdef CFG_RAMP_SOFT_DOWN_EN
    typedef enum logic [1:0] {S_IDLE, S_UP, S_DN, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_UP, S_FAULT} state_t;
`endif

    state_t            state_q;
    logic              fsync_q;
    logic              fs_q;
    logic [DIV_W-1:0]  div_q;
    logic              pend_q;
    logic [DATA_W-1:0] cur_q;
    logic [DATA_W-1:0] tgt_q;
    logic              hold_vld_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_data_q;
    logic              out_en_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;

    logic              in_busy;
    logic              fault_hit;
    logic              wr_ramp;
    logic              wr_fwd;
    logic              jump;
    logic              div_wrap;
    logic              step_req;
    logic              slot_taken;
    logic [DATA_W-1:0] tgt_d;
    logic [DATA_W-1:0] cur_d;
    logic [DATA_W:0]   up_sum;
    logic [DATA_W-1:0] up_val;
    logic [DATA_W:0]   dn_dif;
    logic [DATA_W-1:0] dn_raw;
    logic [DATA_W-1:0] dn_val;

`ifdef CFG_RAMP_SOFT_DOWN_EN
    assign in_busy = (state_q == S_UP) || (state_q == S_DN);
    assign jump    = 1'b0;
`else
    assign in_busy = (state_q == S_UP);
    // Without soft-down, any lower target bypasses the ramp and goes out like a forwarded write
    assign jump    = wr_ramp && (in_data < cur_q) && (state_q != S_FAULT);
`endif

    assign fault_hit  = fs_q && (state_q != S_FAULT);
    assign wr_ramp    = in_en && (in_addr == RA);
    assign wr_fwd     = in_en && (in_addr != RA);
    assign div_wrap   = (div_q == DIV_MAX);
    assign step_req   = in_busy && (div_wrap || pend_q);
    assign slot_taken = hold_vld_q || wr_fwd;

    // A target written in the same cycle as a step is honoured by that step
    always_comb begin
        tgt_d  = wr_ramp ? in_data : tgt_q;
        up_sum = {1'b0, cur_q} + STEP_X;
        up_val = (up_sum > {1'b0, tgt_d}) ? tgt_d : up_sum[DATA_W-1:0];
        dn_dif = {1'b0, cur_q} - STEP_X;
        dn_raw = dn_dif[DATA_W] ? '0 : dn_dif[DATA_W-1:0];
        dn_val = (dn_raw < tgt_d) ? tgt_d : dn_raw;
        cur_d  = (tgt_d > cur_q) ? up_val : dn_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fsync_q     <= 1'b0;
            fs_q        <= 1'b0;
            div_q       <= '0;
            pend_q      <= 1'b0;
            cur_q       <= '0;
            tgt_q       <= '0;
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            out_en_q    <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            fsync_q  <= fault;
            fs_q     <= fsync_q;
            out_en_q <= 1'b0;
            div_q    <= (in_busy && !div_wrap) ? div_q + DIV_W'(1) : '0;

            if (fault_hit) begin
                out_en_q   <= 1'b1;
                out_addr_q <= RA;
                out_data_q <= '0;
                cur_q      <= '0;
                tgt_q      <= '0;
                pend_q     <= 1'b0;
                state_q    <= S_FAULT;
                if (wr_fwd) begin
                    hold_vld_q  <= 1'b1;
                    hold_addr_q <= in_addr;
                    hold_data_q <= in_data;
                end
            end else begin
                if (hold_vld_q) begin
                    out_en_q    <= 1'b1;
                    out_addr_q  <= hold_addr_q;
                    out_data_q  <= hold_data_q;
                    hold_vld_q  <= wr_fwd;
                    if (wr_fwd) begin
                        hold_addr_q <= in_addr;
                        hold_data_q <= in_data;
                    end
                end else if (wr_fwd || jump) begin
                    out_en_q   <= 1'b1;
                    out_addr_q <= in_addr;
                    out_data_q <= in_data;
                end

                case (state_q)
                    S_IDLE: begin
                        if (wr_ramp) begin
                            tgt_q <= in_data;
                            if (in_data > cur_q) state_q <= S_UP;
`ifdef CFG_RAMP_SOFT_DOWN_EN
                            else if (in_data < cur_q) state_q <= S_DN;
`else
                            else if (jump) cur_q <= in_data;
`endif
                        end
                    end
`ifdef CFG_RAMP_SOFT_DOWN_EN
                    S_UP, S_DN: begin
`else
                    S_UP: begin
`endif
                        if (wr_ramp) tgt_q <= in_data;
                        if (jump) begin
                            cur_q   <= in_data;
                            pend_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (step_req) begin
                            if (slot_taken) begin
                                pend_q <= 1'b1;
                            end else begin
                                pend_q <= 1'b0;
                                if (tgt_d == cur_q) begin
                                    state_q <= S_IDLE;
                                end else begin
                                    out_en_q   <= 1'b1;
                                    out_addr_q <= RA;
                                    out_data_q <= cur_d;
                                    cur_q      <= cur_d;
                                    if (cur_d == tgt_d) state_q <= S_IDLE;
`ifdef CFG_RAMP_SOFT_DOWN_EN
                                    else if (tgt_d < cur_q) state_q <= S_DN;
`endif
                                    else state_q <= S_UP;
                                end
                            end
                        end
                    end
                    S_FAULT: begin
                        if (wr_ramp && (in_data == '0) && !fs_q) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign out_en     = out_en_q;
    assign cur_val    = cur_q;
    assign busy       = in_busy;
    assign fault_lock = (state_q == S_FAULT);

endmodule

// File: tb/tb_cfg_ramp_seq.sv
// tb/tb_cfg_ramp_seq.sv - directed bench for cfg_ramp_seq with RAMP_DIV=4, RAMP_STEP=4
module tb_cfg_ramp_seq;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RA = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_addr = '0;
    logic          in_en = 1'b0;
    logic          fault = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_en;
    logic [DW-1:0] cur_val;
    logic          busy;
    logic          fault_lock;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t wlog[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;

    cfg_ramp_seq #(
        .DATA_W(DW), .ADDR_W(AW), .RAMP_ADDR(RA), .RAMP_STEP(4), .RAMP_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_addr(in_addr), .in_en(in_en),
        .fault(fault), .out_data(out_data), .out_addr(out_addr), .out_en(out_en),
        .cur_val(cur_val), .busy(busy), .fault_lock(fault_lock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rst_n && out_en === 1'b1) wlog.push_back('{cyc, out_addr, out_data});

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic uart_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_addr = a;
        in_data = d;
        in_en   = 1'b1;
        @(negedge clk);
        in_en   = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, lim);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk += 6;
        if (out_en !== 1'b0) $display("FAIL reset out_en: got %b want 0", out_en); else n_pass++;
        if (out_data !== '0) $display("FAIL reset out_data: got %0h want 0", out_data); else n_pass++;
        if (out_addr !== '0) $display("FAIL reset out_addr: got %0h want 0", out_addr); else n_pass++;
        if (cur_val !== '0) $display("FAIL reset cur_val: got %0d want 0", cur_val); else n_pass++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
        if (fault_lock !== 1'b0) $display("FAIL reset fault_lock: got %b want 0", fault_lock); else n_pass++;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++;
        if (wlog.size() != 0) $display("FAIL reset idle writes: got %0d want 0", wlog.size()); else n_pass++;
    endtask

    task automatic test_forward();
        int base;
        wlog.delete();
        base = cyc;
        uart_wr(4'd2, 8'h1E);
        go_to(base + 5);
        n_chk++;
        if (wlog.size() != 1) $display("FAIL forward count: got %0d want 1", wlog.size());
        else begin
            n_pass++;
            n_chk++;
            if (wlog[0].cyc !== base + 1 || wlog[0].a !== 4'd2 || wlog[0].d !== 8'h1E)
                $display("FAIL forward write: got lat=%0d addr=%0d data=%0h want lat=1 addr=2 data=1e",
                         wlog[0].cyc - base, wlog[0].a, wlog[0].d);
            else n_pass++;
        end
    endtask

    task automatic test_soft_start();
        int base;
        int ec[$];
        logic [DW-1:0] ed[$];
        wlog.delete();
        base = cyc;
        uart_wr(4'(RA), 8'd10);
        ec = '{base + 5, base + 9, base + 13};
        ed = '{8'd4, 8'd8, 8'd10};
        go_to(base + 12);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL soft_start busy before last: got %b want 1", busy); else n_pass++;
        go_to(base + 13);
        n_chk += 2;
        if (busy !== 1'b0) $display("FAIL soft_start busy at last: got %b want 0", busy); else n_pass++;
        if (cur_val !== 8'd10) $display("FAIL soft_start cur_val: got %0d want 10", cur_val); else n_pass++;
        go_to(base + 16);
        n_chk++;
        if (wlog.size() != ec.size()) $display("FAIL soft_start count: got %0d want %0d", wlog.size(), ec.size());
        else n_pass++;
        for (int i = 0; i < ec.size(); i++) begin
            n_chk++;
            if (i >= wlog.size()) $display("FAIL soft_start wr%0d: got none want data=%0d", i, ed[i]);
            else if (wlog[i].cyc !== ec[i] || wlog[i].a !== 4'(RA) || wlog[i].d !== ed[i])
                $display("FAIL soft_start wr%0d: got t=%0d addr=%0d data=%0d want t=%0d addr=%0d data=%0d",
                         i, wlog[i].cyc - base, wlog[i].a, wlog[i].d, ec[i] - base, RA, ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        int base;
        int ec[$];
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        wlog.delete();
        base = cyc;
        uart_wr(4'(RA), 8'd30);
        go_to(base + 4);
        uart_wr(4'd1, 8'hAB);
        ec = '{base + 5, base + 6, base + 9, base + 13, base + 17, base + 21};
        ea = '{4'd1, 4'(RA), 4'(RA), 4'(RA), 4'(RA), 4'(RA)};
        ed = '{8'hAB, 8'd14, 8'd18, 8'd22, 8'd26, 8'd30};
        go_to(base + 24);
        n_chk += 2;
        if (cur_val !== 8'd30) $display("FAIL collision cur_val: got %0d want 30", cur_val); else n_pass++;
        if (wlog.size() != ec.size()) $display("FAIL collision count: got %0d want %0d", wlog.size(), ec.size());
        else n_pass++;
        for (int i = 0; i < ec.size(); i++) begin
            n_chk++;
            if (i >= wlog.size()) $display("FAIL collision wr%0d: got none want data=%0d", i, ed[i]);
            else if (wlog[i].cyc !== ec[i] || wlog[i].a !== ea[i] || wlog[i].d !== ed[i])
                $display("FAIL collision wr%0d: got t=%0d addr=%0d data=%0d want t=%0d addr=%0d data=%0d",
                         i, wlog[i].cyc - base, wlog[i].a, wlog[i].d, ec[i] - base, ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_soft_down();
        int base;
        int stop;
        logic exp_busy;
        int ec[$];
        logic [DW-1:0] ed[$];
        uart_wr(4'(RA), 8'd40);
        wait_idle(100);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (cur_val !== 8'd40) $display("FAIL soft_down setup cur_val: got %0d want 40", cur_val); else n_pass++;
        wlog.delete();
        base = cyc;
        uart_wr(4'(RA), 8'd60);
        uart_wr(4'(RA), 8'd20);
`ifdef CFG_RAMP_SOFT_DOWN_EN
        exp_busy = 1'b1;
        stop = base + 24;
        ec = '{base + 5, base + 9, base + 13, base + 17, base + 21};
        ed = '{8'd36, 8'd32, 8'd28, 8'd24, 8'd20};
`else
        exp_busy = 1'b0;
        stop = base + 8;
        ec = '{base + 2};
        ed = '{8'd20};
`endif
        go_to(base + 3);
        n_chk++;
        if (busy !== exp_busy) $display("FAIL soft_down busy: got %b want %b", busy, exp_busy); else n_pass++;
        go_to(stop);
        n_chk += 3;
        if (cur_val !== 8'd20) $display("FAIL soft_down cur_val: got %0d want 20", cur_val); else n_pass++;
        if (busy !== 1'b0) $display("FAIL soft_down end busy: got %b want 0", busy); else n_pass++;
        if (wlog.size() != ec.size()) $display("FAIL soft_down count: got %0d want %0d", wlog.size(), ec.size());
        else n_pass++;
        for (int i = 0; i < ec.size(); i++) begin
            n_chk++;
            if (i >= wlog.size()) $display("FAIL soft_down wr%0d: got none want data=%0d", i, ed[i]);
            else if (wlog[i].cyc !== ec[i] || wlog[i].a !== 4'(RA) || wlog[i].d !== ed[i])
                $display("FAIL soft_down wr%0d: got t=%0d addr=%0d data=%0d want t=%0d addr=%0d data=%0d",
                         i, wlog[i].cyc - base, wlog[i].a, wlog[i].d, ec[i] - base, RA, ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_ramp();
        int base;
        wlog.delete();
        base = cyc;
        uart_wr(4'(RA), 8'd40);
        go_to(base + 10);
        n_chk++;
        if (cur_val !== 8'd28) $display("FAIL mid_reset setup cur_val: got %0d want 28", cur_val); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk += 4;
        if (out_data !== '0) $display("FAIL mid_reset out_data: got %0d want 0", out_data); else n_pass++;
        if (out_addr !== '0) $display("FAIL mid_reset out_addr: got %0d want 0", out_addr); else n_pass++;
        if (cur_val !== '0) $display("FAIL mid_reset cur_val: got %0d want 0", cur_val); else n_pass++;
        if (busy !== 1'b0) $display("FAIL mid_reset busy: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
        repeat (20) @(negedge clk);
        n_chk += 2;
        if (wlog.size() != 0) $display("FAIL mid_reset writes after release: got %0d want 0", wlog.size()); else n_pass++;
        if (busy !== 1'b0) $display("FAIL mid_reset busy after release: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_fault();
        int base;
        int ec[$];
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        wlog.delete();
        base = cyc;
        uart_wr(4'(RA), 8'd20);
        go_to(base + 10);
        n_chk++;
        if (cur_val !== 8'd8) $display("FAIL fault setup cur_val: got %0d want 8", cur_val); else n_pass++;
        fault = 1'b1;
        go_to(base + 13);
        n_chk += 3;
        if (fault_lock !== 1'b1) $display("FAIL fault lock: got %b want 1", fault_lock); else n_pass++;
        if (busy !== 1'b0) $display("FAIL fault busy: got %b want 0", busy); else n_pass++;
        if (cur_val !== 8'd0) $display("FAIL fault cur_val: got %0d want 0", cur_val); else n_pass++;
        go_to(base + 14);
        uart_wr(4'(RA), 8'd20);
        uart_wr(4'd2, 8'h55);
        go_to(base + 17);
        n_chk++;
        if (fault_lock !== 1'b1) $display("FAIL fault lock held: got %b want 1", fault_lock); else n_pass++;
        fault = 1'b0;
        go_to(base + 20);
        uart_wr(4'(RA), 8'd0);
        go_to(base + 23);
        n_chk += 2;
        if (fault_lock !== 1'b0) $display("FAIL fault release lock: got %b want 0", fault_lock); else n_pass++;
        if (cur_val !== 8'd0) $display("FAIL fault release cur_val: got %0d want 0", cur_val); else n_pass++;
        ec = '{base + 5, base + 9, base + 13, base + 16};
        ea = '{4'(RA), 4'(RA), 4'(RA), 4'd2};
        ed = '{8'd4, 8'd8, 8'd0, 8'h55};
        n_chk++;
        if (wlog.size() != ec.size()) $display("FAIL fault count: got %0d want %0d", wlog.size(), ec.size());
        else n_pass++;
        for (int i = 0; i < ec.size(); i++) begin
            n_chk++;
            if (i >= wlog.size()) $display("FAIL fault wr%0d: got none want data=%0d", i, ed[i]);
            else if (wlog[i].cyc !== ec[i] || wlog[i].a !== ea[i] || wlog[i].d !== ed[i])
                $display("FAIL fault wr%0d: got t=%0d addr=%0d data=%0d want t=%0d addr=%0d data=%0d",
                         i, wlog[i].cyc - base, wlog[i].a, wlog[i].d, ec[i] - base, ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fault_collision();
        int base;
        int ec[$];
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        wlog.delete();
        base = cyc;
        fault = 1'b1;
        go_to(base + 2);
        uart_wr(4'd3, 8'h77);
        go_to(base + 5);
        n_chk++;
        if (fault_lock !== 1'b1) $display("FAIL fault_coll lock: got %b want 1", fault_lock); else n_pass++;
        fault = 1'b0;
        go_to(base + 9);
        uart_wr(4'(RA), 8'd0);
        go_to(base + 12);
        n_chk += 2;
        if (fault_lock !== 1'b0) $display("FAIL fault_coll release: got %b want 0", fault_lock); else n_pass++;
        ec = '{base + 3, base + 4};
        ea = '{4'(RA), 4'd3};
        ed = '{8'd0, 8'h77};
        if (wlog.size() != ec.size()) $display("FAIL fault_coll count: got %0d want %0d", wlog.size(), ec.size());
        else n_pass++;
        for (int i = 0; i < ec.size(); i++) begin
            n_chk++;
            if (i >= wlog.size()) $display("FAIL fault_coll wr%0d: got none want data=%0h", i, ed[i]);
            else if (wlog[i].cyc !== ec[i] || wlog[i].a !== ea[i] || wlog[i].d !== ed[i])
                $display("FAIL fault_coll wr%0d: got t=%0d addr=%0d data=%0h want t=%0d addr=%0d data=%0h",
                         i, wlog[i].cyc - base, wlog[i].a, wlog[i].d, ec[i] - base, ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_soft_start();
        test_collision();
        test_soft_down();
        test_reset_mid_ramp();
        test_fault();
        test_fault_collision();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
